// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module : fft_pkg
// Brief  : Shared defaults and fixed-point helpers for the SDF FFT pipeline.
// Rev    : 1.0  initial release
// ============================================================================
package fft_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int LOG_N_DEF = 6;
    localparam int FRAME_LEN = 64;
    localparam int Q15_SHIFT = WIDTH_DEF - 1;

    // Saturation limits of a signed w-bit word.
    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_cmult.sv
`default_nettype none
// ============================================================================
// Module : twiddle_cmult
// Brief  : Registered complex multiply, Q15 scale, saturate, with bypass.
//          TWIDDLE_ROUND_EN selects round-half-up instead of floor.
// Rev    : 1.0  initial release
// ============================================================================
module twiddle_cmult
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    bypass,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] tw_re,
    input  logic signed [WIDTH-1:0] tw_im,
    output logic        [WIDTH-1:0] y_re,
    output logic        [WIDTH-1:0] y_im
);

    localparam int PW  = 2 * WIDTH;
    localparam int PW1 = PW + 1;
    localparam logic signed [PW:0] SAT_HI = PW1'(sat_hi(WIDTH));
    localparam logic signed [PW:0] SAT_LO = PW1'(sat_lo(WIDTH));
`ifdef TWIDDLE_ROUND_EN
    localparam logic signed [PW:0] ROUND_BIAS = PW1'(longint'(1) <<< (WIDTH - 2));
`endif

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                 byp3;
    logic [WIDTH-1:0]     d3_re, d3_im;
    logic signed [PW:0]   sum_re, sum_im, sc_re, sc_im;

    function automatic logic [WIDTH-1:0] sat(input logic signed [PW:0] v);
        if (v > SAT_HI)      sat = SAT_HI[WIDTH-1:0];
        else if (v < SAT_LO) sat = SAT_LO[WIDTH-1:0];
        else                 sat = v[WIDTH-1:0];
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_rr  <= '0;
            p_ii  <= '0;
            p_ri  <= '0;
            p_ir  <= '0;
            byp3  <= 1'b0;
            d3_re <= '0;
            d3_im <= '0;
        end else begin
            p_rr  <= PW'(a_re) * PW'(tw_re);
            p_ii  <= PW'(a_im) * PW'(tw_im);
            p_ri  <= PW'(a_re) * PW'(tw_im);
            p_ir  <= PW'(a_im) * PW'(tw_re);
            byp3  <= bypass;
            d3_re <= a_re;
            d3_im <= a_im;
        end
    end

    // One guard bit keeps the sum exact before scaling.
    always_comb begin
        sum_re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
        sum_im = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
`ifdef TWIDDLE_ROUND_EN
        sum_re = sum_re + ROUND_BIAS;
        sum_im = sum_im + ROUND_BIAS;
`endif
        sc_re = sum_re >>> (WIDTH - 1);
        sc_im = sum_im >>> (WIDTH - 1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            y_re <= '0;
            y_im <= '0;
        end else if (load) begin
            y_re <= byp3 ? d3_re : sat(sc_re);
            y_im <= byp3 ? d3_im : sat(sc_im);
        end
    end

endmodule
`default_nettype wire

// File: rtl/twiddle_rom.sv
`default_nettype none
// ============================================================================
// Module : twiddle_rom
// Brief  : 64-entry Q1.15 twiddle table W64^k = cos - j*sin, optional output FF.
// Rev    : 1.0  initial release
// ============================================================================
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TW_FF = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [5:0]       addr,
    output logic [WIDTH-1:0] tw_re,
    output logic [WIDTH-1:0] tw_im
);

    // Quarter-wave table round(32768*cos(j*pi/32)), +1.0 clipped to 32767.
    function automatic logic signed [15:0] quarter(input logic [4:0] j);
        case (j)
            5'd0:    quarter = 16'sd32767;
            5'd1:    quarter = 16'sd32610;
            5'd2:    quarter = 16'sd32138;
            5'd3:    quarter = 16'sd31357;
            5'd4:    quarter = 16'sd30274;
            5'd5:    quarter = 16'sd28899;
            5'd6:    quarter = 16'sd27246;
            5'd7:    quarter = 16'sd25330;
            5'd8:    quarter = 16'sd23170;
            5'd9:    quarter = 16'sd20788;
            5'd10:   quarter = 16'sd18205;
            5'd11:   quarter = 16'sd15447;
            5'd12:   quarter = 16'sd12540;
            5'd13:   quarter = 16'sd9512;
            5'd14:   quarter = 16'sd6393;
            5'd15:   quarter = 16'sd3212;
            default: quarter = 16'sd0;
        endcase
    endfunction

    logic signed [15:0] cos_j, sin_j, cos_k, sin_k;
    logic [WIDTH-1:0]   re_c, im_c;

    always_comb begin
        cos_j = quarter({1'b0, addr[3:0]});
        sin_j = quarter(5'd16 - {1'b0, addr[3:0]});
        case (addr[5:4])
            2'd0:    begin cos_k = cos_j;  sin_k = sin_j;  end
            2'd1:    begin cos_k = -sin_j; sin_k = cos_j;  end
            2'd2:    begin cos_k = -cos_j; sin_k = -sin_j; end
            default: begin cos_k = sin_j;  sin_k = -cos_j; end
        endcase
        re_c = WIDTH'(cos_k);
        im_c = WIDTH'(-sin_k);
    end

    generate
        if (TW_FF != 0) begin : g_reg
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    tw_re <= '0;
                    tw_im <= '0;
                end else begin
                    tw_re <= re_c;
                    tw_im <= im_c;
                end
            end
        end else begin : g_comb
            assign tw_re = re_c;
            assign tw_im = im_c;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/twiddle_rotator.sv
`default_nettype none
// ============================================================================
// Module : twiddle_rotator
// Brief  : Radix-2^2 twiddle address generator and 4-stage sample rotator.
//          TWIDDLE_ROUND_EN (optional) enables round-half-up scaling.
// Rev    : 1.0  initial release
// ============================================================================
module twiddle_rotator
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LOG_N = LOG_N_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_start
);

    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(FRAME_LEN - 1);

    logic [LOG_N-1:0] cnt;
    logic [1:0]       sel;
    logic [3:0]       num;
    logic [5:0]       addr_nxt;

    logic [WIDTH-1:0] s1_re, s1_im, s2_re, s2_im;
    logic [5:0]       s1_addr;
    logic             s1_valid, s1_start, s1_byp;
    logic             s2_valid, s2_start, s2_byp;
    logic             s3_valid, s3_start;
    logic [WIDTH-1:0] tw_re, tw_im;

    // Max product 15*3 = 45, so six bits hold the address losslessly.
    assign sel      = {cnt[4], cnt[5]};
    assign num      = cnt[3:0];
    assign addr_nxt = {2'b00, num} * {4'b0000, sel};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_addr  <= '0;
            s1_valid <= 1'b0;
            s1_start <= 1'b0;
            s1_byp   <= 1'b0;
            s2_re    <= '0;
            s2_im    <= '0;
            s2_valid <= 1'b0;
            s2_start <= 1'b0;
            s2_byp   <= 1'b0;
            s3_valid <= 1'b0;
            s3_start <= 1'b0;
            do_en    <= 1'b0;
            do_start <= 1'b0;
        end else begin
            if (di_en) begin
                cnt <= (cnt == LAST_IDX) ? '0 : cnt + LOG_N'(1);
            end
            s1_re    <= di_re;
            s1_im    <= di_im;
            s1_addr  <= addr_nxt;
            s1_valid <= di_en;
            s1_start <= di_en && (cnt == '0);
            s1_byp   <= (addr_nxt == '0);
            s2_re    <= s1_re;
            s2_im    <= s1_im;
            s2_valid <= s1_valid;
            s2_start <= s1_start;
            s2_byp   <= s1_byp;
            s3_valid <= s2_valid;
            s3_start <= s2_start;
            do_en    <= s3_valid;
            do_start <= s3_start;
        end
    end

    twiddle_rom #(
        .WIDTH (WIDTH),
        .TW_FF (1)
    ) u_rom (
        .clock   (clock),
        .reset_n (reset_n),
        .addr    (s1_addr),
        .tw_re   (tw_re),
        .tw_im   (tw_im)
    );

    twiddle_cmult #(
        .WIDTH (WIDTH)
    ) u_cmult (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (s3_valid),
        .bypass  (s2_byp),
        .a_re    (s2_re),
        .a_im    (s2_im),
        .tw_re   (tw_re),
        .tw_im   (tw_im),
        .y_re    (do_re),
        .y_im    (do_im)
    );

endmodule
`default_nettype wire

// File: tb/tb_twiddle_rotator.sv
`default_nettype none
// ============================================================================
// Module : tb_twiddle_rotator
// Brief  : Randomized self-checking bench for twiddle_rotator against a
//          trigonometric reference model; honours TWIDDLE_ROUND_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_twiddle_rotator;

    localparam int  W  = 16;
    localparam real PI = 3.14159265358979323846;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic         di_en   = 1'b0;
    logic [W-1:0] di_re   = '0;
    logic [W-1:0] di_im   = '0;
    logic         do_en, do_start;
    logic [W-1:0] do_re, do_im;

    twiddle_rotator #(.WIDTH(W), .LOG_N(6)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .di_en    (di_en),
        .di_re    (di_re),
        .di_im    (di_im),
        .do_en    (do_en),
        .do_re    (do_re),
        .do_im    (do_im),
        .do_start (do_start)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          en;
        bit          start;
        logic [15:0] re, im;
        bit          gold;
        logic [15:0] gre, gim;
    } exp_t;

    exp_t        pipe[$];
    logic [31:0] obs_log[$];
    logic [31:0] log_a[$];
    int          checks = 0, failures = 0;
    int          m_cnt = 0, cyc = 0;
    logic [15:0] last_re = '0, last_im = '0;
    int          starts_seen = 0, last_start_cyc = 0, start_gap = 0;
    int          first_start_cyc = -1, en_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic longint rnd(input real x);
        return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(-x + 0.5));
    endfunction

    function automatic longint clip(input longint v, input longint lim);
        return (v > lim) ? lim : ((v < -lim - 1) ? -lim - 1 : v);
    endfunction

    // Reference rotation: sample k of the frame times W64^addr in Q1.15.
    function automatic void rotate(input int k, input logic [15:0] re, input logic [15:0] im,
                                   output logic [15:0] ore, output logic [15:0] oim);
        int     addr;
        longint tr, ti, xr, xi, yr, yi;
        addr = (k % 16) * (2 * ((k / 16) % 2) + k / 32);
        if (addr == 0) begin
            ore = re;
            oim = im;
            return;
        end
        tr = rnd(32768.0 * $cos(2.0 * PI * addr / 64.0));
        ti = rnd(-32768.0 * $sin(2.0 * PI * addr / 64.0));
        // The table holds magnitudes up to 32767 only.
        if (tr > 32767) tr = 32767;
        if (tr < -32767) tr = -32767;
        if (ti > 32767) ti = 32767;
        if (ti < -32767) ti = -32767;
        xr = longint'($signed(re));
        xi = longint'($signed(im));
        yr = xr * tr - xi * ti;
        yi = xr * ti + xi * tr;
`ifdef TWIDDLE_ROUND_EN
        yr = yr + 16384;
        yi = yi + 16384;
`endif
        yr = clip(yr >>> 15, 32767);
        yi = clip(yi >>> 15, 32767);
        ore = yr[15:0];
        oim = yi[15:0];
    endfunction

    function automatic logic [15:0] rnd_sample();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic model_clear();
        exp_t idle;
        idle = '{en: 1'b0, start: 1'b0, re: '0, im: '0, gold: 1'b0, gre: '0, gim: '0};
        pipe.delete();
        repeat (4) pipe.push_back(idle);
        m_cnt   = 0;
        last_re = '0;
        last_im = '0;
    endtask

    task automatic step(input bit en, input logic [15:0] re, input logic [15:0] im);
        exp_t e, o;
        @(posedge clock);
        #1;
        cyc++;
        di_en = en;
        di_re = re;
        di_im = im;
        e = '{en: en, start: en && (m_cnt == 0), re: '0, im: '0, gold: 1'b0, gre: '0, gim: '0};
        if (en) begin
            rotate(m_cnt, re, im, e.re, e.im);
            if (re == 16'h4000 && im == 16'h0000 && m_cnt <= 16) begin
                e.gold = 1'b1; e.gre = 16'h4000; e.gim = 16'h0000;
            end else if (re == 16'h4000 && im == 16'h0000 && m_cnt == 20) begin
                e.gold = 1'b1; e.gre = 16'h2D41; e.gim = 16'hD2BF;
            end else if (re == 16'h4000 && im == 16'h0000 && m_cnt == 17) begin
`ifdef TWIDDLE_ROUND_EN
                e.gold = 1'b1; e.gre = 16'h3EC5; e.gim = 16'hF384;
`else
                e.gold = 1'b1; e.gre = 16'h3EC5; e.gim = 16'hF383;
`endif
            end else if (re == 16'h8000 && im == 16'h8000 && m_cnt == 20) begin
                e.gold = 1'b1; e.gre = 16'h8000; e.gim = 16'h0000;
            end
            m_cnt = (m_cnt + 1) % 64;
        end
        pipe.push_back(e);
        @(negedge clock);
        o = pipe.pop_front();
        if (o.en) begin
            last_re = o.re;
            last_im = o.im;
        end
        check("do_en", 32'(do_en), 32'(o.en));
        check("do_start", 32'(do_start), 32'(o.start));
        check("do_re", 32'(do_re), 32'(last_re));
        check("do_im", 32'(do_im), 32'(last_im));
        if (o.gold) begin
            check("directed_re", 32'(do_re), 32'(o.gre));
            check("directed_im", 32'(do_im), 32'(o.gim));
        end
        if (do_en === 1'b1) obs_log.push_back({do_re, do_im});
        if (do_start === 1'b1) begin
            if (starts_seen > 0) start_gap = cyc - last_start_cyc;
            starts_seen++;
            last_start_cyc = cyc;
            if (first_start_cyc < 0) first_start_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        di_en   = 1'b0;
        #1;
        check("rst_en", 32'(do_en), 32'd0);
        check("rst_start", 32'(do_start), 32'd0);
        check("rst_re", 32'(do_re), 32'd0);
        check("rst_im", 32'(do_im), 32'd0);
        repeat (2) @(negedge clock);
        check("rst_hold", {do_en, do_start, do_re, do_im}, 32'd0);
        reset_n = 1'b1;
        model_clear();
        first_start_cyc = -1;
    endtask

    task automatic flush();
        repeat (5) step(1'b0, '0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "bench time limit expired");
    end

    initial begin
        do_reset();

        // Continuous frame of (0x4000, 0).
        obs_log.delete();
        for (int i = 0; i < 64; i++) step(1'b1, 16'h4000, 16'h0000);
        flush();
        log_a = obs_log;

        // Same frame gapped 1-on / 2-off.
        obs_log.delete();
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 16'h4000, 16'h0000);
            step(1'b0, 16'h1234, 16'h5678);
            step(1'b0, 16'h1234, 16'h5678);
        end
        flush();
        check("gap_count", 32'(obs_log.size()), 32'(log_a.size()));
        for (int i = 0; i < 64 && i < obs_log.size() && i < log_a.size(); i++)
            check("gap_order", obs_log[i], log_a[i]);

        // Saturation frame of (0x8000, 0x8000).
        for (int i = 0; i < 64; i++) step(1'b1, 16'h8000, 16'h8000);
        flush();

        // Reset at index 37, then a full fresh frame.
        for (int i = 0; i < 37; i++) step(1'b1, rnd_sample(), rnd_sample());
        do_reset();
        step(1'b1, rnd_sample(), rnd_sample());
        en_cyc = cyc;
        for (int i = 1; i < 64; i++) step(1'b1, rnd_sample(), rnd_sample());
        flush();
        check("start_latency", 32'(first_start_cyc - en_cyc), 32'd4);

        // 128 back-to-back random samples: two frame starts 64 clocks apart.
        do_reset();
        starts_seen = 0;
        start_gap   = 0;
        for (int i = 0; i < 128; i++) step(1'b1, rnd_sample(), rnd_sample());
        flush();
        check("start_count", 32'(starts_seen), 32'd2);
        check("start_gap", 32'(start_gap), 32'd64);

        // Random traffic with random idle gaps.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 2) != 0, rnd_sample(), rnd_sample());
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
